// File: rtl/dc_bu_read_manager.sv
// Read-side manager of the line-buffering unit: issues RAM reads oldest-buffer-first and releases lines.
// Optional vertical line replication is enabled with `define DC_BU_LINE_REPEAT_EN.
module dc_bu_read_manager #(
  parameter int unsigned BUFF_ADDR_WIDTH       = 7,
  parameter int unsigned BUFFER_SIZE           = 128,
  parameter int unsigned BUFFER_NUM            = 5,
  parameter int unsigned PIXELS_PER_LINE_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               en,
  input  logic [PIXELS_PER_LINE_WIDTH-1:0]   pixels_per_line,
`ifdef DC_BU_LINE_REPEAT_EN
  input  logic [3:0]                         line_repeat,
`endif
  input  logic                               line_written,
  input  logic                               rd_ready,
  output logic [BUFF_ADDR_WIDTH-1:0]         mem_addr,
  output logic [BUFFER_NUM-1:0]              re_vec,
  output logic                               pix_valid,
  output logic                               line_read_done,
  output logic [$clog2(BUFFER_NUM+1)-1:0]    lines_avail,
  output logic                               buf_full,
  output logic                               overflow_err
);

  localparam int unsigned LEN_W = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned CNT_W = $clog2(BUFFER_NUM + 1);

  typedef enum logic [1:0] {IDLE, READ, TURN, RELEASE} state_t;

  state_t                 state;
  logic [BUFFER_NUM-1:0]  rd_ptr;
  logic [LEN_W-1:0]       addr_cnt;
  logic [LEN_W-1:0]       len;
`ifdef DC_BU_LINE_REPEAT_EN
  logic [3:0]             rep_left;
`endif

  logic                   issue_c;
  logic                   last_c;
  logic [LEN_W-1:0]       len_start_c;
  logic [CNT_W-1:0]       avail_nxt_c;

  // Read issue decision and clamped line length for the next line start
  always_comb begin
    issue_c     = (state == READ) && en && rd_ready && (addr_cnt < len);
    last_c      = issue_c && (addr_cnt == len - LEN_W'(1));
    len_start_c = (32'(pixels_per_line) > BUFFER_SIZE) ? LEN_W'(BUFFER_SIZE)
                                                       : LEN_W'(pixels_per_line);
  end

  // Occupancy: saturates at BUFFER_NUM, simultaneous fill and release cancel out
  always_comb begin
    avail_nxt_c = lines_avail;
    if (line_written && !line_read_done && !buf_full)
      avail_nxt_c = lines_avail + CNT_W'(1);
    else if (!line_written && line_read_done)
      avail_nxt_c = lines_avail - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lines_avail  <= '0;
      buf_full     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      lines_avail <= avail_nxt_c;
      buf_full    <= (avail_nxt_c == CNT_W'(BUFFER_NUM));
      if (line_written && !line_read_done && buf_full)
        overflow_err <= 1'b1;
    end
  end

  // Read FSM; RELEASE always completes in one cycle so the release pulse is never stretched
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      rd_ptr         <= BUFFER_NUM'(1);
      addr_cnt       <= '0;
      len            <= '0;
      mem_addr       <= '0;
      re_vec         <= '0;
      pix_valid      <= 1'b0;
      line_read_done <= 1'b0;
`ifdef DC_BU_LINE_REPEAT_EN
      rep_left       <= '0;
`endif
    end else begin
      re_vec         <= '0;
      pix_valid      <= |re_vec;
      line_read_done <= 1'b0;
      if (issue_c) begin
        re_vec   <= rd_ptr;
        mem_addr <= BUFF_ADDR_WIDTH'(addr_cnt);
        addr_cnt <= addr_cnt + LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (en && lines_avail != '0) begin
            state    <= READ;
            addr_cnt <= '0;
            len      <= len_start_c;
`ifdef DC_BU_LINE_REPEAT_EN
            rep_left <= line_repeat;
`endif
          end
        end
        READ: begin
          if (en && len == '0) begin
            state          <= RELEASE;
            line_read_done <= 1'b1;
          end else if (last_c) begin
`ifdef DC_BU_LINE_REPEAT_EN
            if (rep_left != '0) begin
              state    <= TURN;
              rep_left <= rep_left - 4'd1;
            end else begin
              state          <= RELEASE;
              line_read_done <= 1'b1;
            end
`else
            state          <= RELEASE;
            line_read_done <= 1'b1;
`endif
          end
        end
        TURN: begin
          if (en) begin
            state    <= READ;
            addr_cnt <= '0;
          end
        end
        RELEASE: begin
          state  <= IDLE;
          rd_ptr <= {rd_ptr[BUFFER_NUM-2:0], rd_ptr[BUFFER_NUM-1]};
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_bu_read_manager.sv
// Self-checking bench for dc_bu_read_manager: directed scenarios plus randomized lines
// checked against a queue-based model of the expected read stream.
module tb_dc_bu_read_manager;

  localparam int unsigned AW = 7;
  localparam int unsigned BS = 128;
  localparam int unsigned BN = 5;
  localparam int unsigned PW = 8;
  localparam int unsigned CW = $clog2(BN + 1);

  logic          clk = 1'b0;
  logic          nrst;
  logic          en;
  logic [PW-1:0] ppl;
  logic          line_written;
  logic          rd_ready;
`ifdef DC_BU_LINE_REPEAT_EN
  logic [3:0]    line_repeat;
`endif
  logic [AW-1:0] mem_addr;
  logic [BN-1:0] re_vec;
  logic          pix_valid;
  logic          line_read_done;
  logic [CW-1:0] lines_avail;
  logic          buf_full;
  logic          overflow_err;

  int n_chk  = 0;
  int n_fail = 0;

  dc_bu_read_manager dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .pixels_per_line(ppl),
`ifdef DC_BU_LINE_REPEAT_EN
    .line_repeat    (line_repeat),
`endif
    .line_written   (line_written),
    .rd_ready       (rd_ready),
    .mem_addr       (mem_addr),
    .re_vec         (re_vec),
    .pix_valid      (pix_valid),
    .line_read_done (line_read_done),
    .lines_avail    (lines_avail),
    .buf_full       (buf_full),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  // Observed read stream, recorded away from the active edge
  logic [AW-1:0] addr_q[$];
  logic [BN-1:0] vec_q[$];
  int            cyc_q[$];
  int            cyc = 0, done_cnt = 0, pv_cnt = 0, pv_bad = 0, gate_bad = 0;
  logic          prev_any = 1'b0, prev_gate = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!nrst) begin
      prev_any  = 1'b0;
      prev_gate = 1'b0;
    end else begin
      if (re_vec != '0) begin
        addr_q.push_back(mem_addr);
        vec_q.push_back(re_vec);
        cyc_q.push_back(cyc);
        if (!prev_gate) gate_bad++;
      end
      if (line_read_done) done_cnt++;
      if (pix_valid) pv_cnt++;
      if (pix_valid !== prev_any) pv_bad++;
      prev_any  = |re_vec;
      prev_gate = en && rd_ready;
    end
  end

  // Reference model: each line yields min(ppl,BS) addresses per pass from the next buffer in rotation
  int            exp_ptr = 0;
  logic [AW-1:0] ea_q[$];
  logic [BN-1:0] ev_q[$];

  function automatic int clamp_len(input int p);
    return (p > int'(BS)) ? int'(BS) : p;
  endfunction

  task automatic model_line(input int p, input int rep);
    logic [BN-1:0] v;
    v = BN'(1) << exp_ptr;
    for (int r = 0; r <= rep; r++)
      for (int a = 0; a < clamp_len(p); a++) begin
        ea_q.push_back(AW'(a));
        ev_q.push_back(v);
      end
    exp_ptr = (exp_ptr + 1) % int'(BN);
  endtask

  task automatic clear_all();
    addr_q.delete(); vec_q.delete(); cyc_q.delete();
    ea_q.delete(); ev_q.delete();
    done_cnt = 0; pv_cnt = 0; pv_bad = 0; gate_bad = 0; exp_ptr = 0;
  endtask

  // Leaves time aligned one unit after a rising edge, reset released
  task automatic do_reset();
    #1 nrst = 1'b0;
    en = 1'b0; rd_ready = 1'b0; line_written = 1'b0; ppl = '0;
`ifdef DC_BU_LINE_REPEAT_EN
    line_repeat = '0;
`endif
    repeat (2) @(negedge clk);
    clear_all();
    @(posedge clk); #1 nrst = 1'b1;
  endtask

  task automatic pulse_written();
    line_written = 1'b1;
    @(posedge clk); #1 line_written = 1'b0;
  endtask

  task automatic run_until_done(input int target, input int budget, output bit ok);
    int c;
    c = 0;
    while (done_cnt < target && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({mem_addr, re_vec, pix_valid, line_read_done, lines_avail, buf_full, overflow_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%0d re=%b pv=%b done=%b avail=%0d full=%b ovf=%b, expected all zero",
               mem_addr, re_vec, pix_valid, line_read_done, lines_avail, buf_full, overflow_err);
    end
    @(posedge clk); #1;
    ppl = 8'd50; en = 1'b1; rd_ready = 1'b1;
    pulse_written();
    repeat (8) begin @(posedge clk); #1; end
    n_chk++;
    if (addr_q.size() == 0) begin
      n_fail++; $display("FAIL midline_active: reads=0, expected >0 before reset");
    end
    #2 nrst = 1'b0;
    #1;
    n_chk++;
    if ({re_vec, pix_valid, line_read_done, lines_avail} !== '0) begin
      n_fail++;
      $display("FAIL midline_async_reset: re=%b pv=%b done=%b avail=%0d, expected zero",
               re_vec, pix_valid, line_read_done, lines_avail);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 nrst = 1'b1;
    n = addr_q.size();
    repeat (6) begin @(posedge clk); #1; end
    n_chk++;
    if (done_cnt !== 0 || addr_q.size() != n || lines_avail !== '0) begin
      n_fail++;
      $display("FAIL midline_abandon: done=%0d extra_reads=%0d avail=%0d, expected 0 0 0",
               done_cnt, addr_q.size() - n, lines_avail);
    end
  endtask

  task automatic test_single_line();
    bit ok;
    do_reset();
    ppl = 8'd4; en = 1'b1; rd_ready = 1'b1;
    pulse_written();
    @(negedge clk);
    n_chk++;
    if (lines_avail !== CW'(1)) begin
      n_fail++; $display("FAIL single_avail_up: got %0d, expected 1", lines_avail);
    end
    @(posedge clk); #1;
    run_until_done(1, 100, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: done=%0d, expected 1", done_cnt); end
    settle();
    model_line(4, 0);
    n_chk++;
    if (addr_q.size() != ea_q.size()) begin
      n_fail++; $display("FAIL single_len: got %0d reads, expected %0d", addr_q.size(), ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < addr_q.size(); i++) begin
      n_chk++;
      if (addr_q[i] !== ea_q[i] || vec_q[i] !== ev_q[i]) begin
        n_fail++;
        $display("FAIL single_rd[%0d]: addr=%0d re=%b, expected addr=%0d re=%b", i, addr_q[i], vec_q[i], ea_q[i], ev_q[i]);
      end
    end
    n_chk++;
    if (cyc_q.size() == 4 && cyc_q[3] - cyc_q[0] != 3) begin
      n_fail++; $display("FAIL single_contig: span=%0d cycles, expected 3", cyc_q[3] - cyc_q[0]);
    end
    n_chk++;
    if (pv_cnt != 4 || pv_bad != 0) begin
      n_fail++; $display("FAIL single_pix_valid: count=%0d bad=%0d, expected 4 0", pv_cnt, pv_bad);
    end
    n_chk++;
    if (done_cnt != 1 || lines_avail !== '0) begin
      n_fail++; $display("FAIL single_release: done=%0d avail=%0d, expected 1 0", done_cnt, lines_avail);
    end
  endtask

  task automatic test_overflow();
    int e;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      pulse_written();
      @(negedge clk);
      e = (k > int'(BN)) ? int'(BN) : k;
      n_chk++;
      if (lines_avail !== CW'(e) || buf_full !== (k >= int'(BN)) || overflow_err !== (k > int'(BN))) begin
        n_fail++;
        $display("FAIL overflow_pulse%0d: avail=%0d full=%b ovf=%b, expected %0d %b %b",
                 k, lines_avail, buf_full, overflow_err, e, (k >= int'(BN)), (k > int'(BN)));
      end
      @(posedge clk); #1;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    ppl = 8'd2; en = 1'b1; rd_ready = 1'b1;
    repeat (60) begin @(posedge clk); #1; end
    n_chk++;
    if (done_cnt != int'(BN) || lines_avail !== '0 || overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: done=%0d avail=%0d ovf=%b, expected %0d 0 1", done_cnt, lines_avail, overflow_err, BN);
    end
    do_reset();
    @(negedge clk);
    n_chk++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b, expected 0", overflow_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_rotation();
    bit ok;
    int p;
    do_reset();
    en = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      p = $urandom_range(1, 6);
      ppl = PW'(p);
      model_line(p, 0);
      pulse_written();
      run_until_done(k + 1, 100, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL rot_timeout%0d: done=%0d", k, done_cnt); end
    end
    settle();
    n_chk++;
    if (addr_q.size() != ea_q.size()) begin
      n_fail++; $display("FAIL rot_len: got %0d reads, expected %0d", addr_q.size(), ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < addr_q.size(); i++) begin
      n_chk++;
      if (addr_q[i] !== ea_q[i] || vec_q[i] !== ev_q[i]) begin
        n_fail++;
        $display("FAIL rot_rd[%0d]: addr=%0d re=%b, expected addr=%0d re=%b", i, addr_q[i], vec_q[i], ea_q[i], ev_q[i]);
      end
    end
  endtask

  task automatic test_clamp_and_zero();
    bit ok;
    do_reset();
    en = 1'b1; rd_ready = 1'b1; ppl = 8'd200;
    pulse_written();
    repeat (10) begin @(posedge clk); #1; end
    ppl = 8'd7;
    run_until_done(1, 400, ok);
    ppl = 8'd0;
    pulse_written();
    run_until_done(2, 50, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL clamp_timeout: done=%0d, expected 2", done_cnt); end
    ppl = 8'd1;
    pulse_written();
    run_until_done(3, 50, ok);
    settle();
    model_line(200, 0); model_line(0, 0); model_line(1, 0);
    n_chk++;
    if (addr_q.size() != ea_q.size() || done_cnt != 3) begin
      n_fail++;
      $display("FAIL clamp_len: got %0d reads %0d releases, expected %0d 3", addr_q.size(), done_cnt, ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < addr_q.size(); i++) begin
      n_chk++;
      if (addr_q[i] !== ea_q[i] || vec_q[i] !== ev_q[i]) begin
        n_fail++;
        $display("FAIL clamp_rd[%0d]: addr=%0d re=%b, expected addr=%0d re=%b", i, addr_q[i], vec_q[i], ea_q[i], ev_q[i]);
      end
    end
  endtask

  task automatic test_throttle_and_coincide();
    bit ok;
    int c;
    logic [11:0] rd_pat, en_pat;
    rd_pat = 12'b1111_1111_0101;
    en_pat = 12'b1111_1000_1111;
    do_reset();
    en = 1'b1; rd_ready = 1'b1; ppl = 8'd8;
    pulse_written();
    c = 0;
    while (addr_q.size() == 0 && c < 20) begin @(posedge clk); #1; c++; end
    for (int i = 0; i < 12; i++) begin
      rd_ready = rd_pat[i]; en = en_pat[i];
      @(posedge clk); #1;
    end
    en = 1'b1; rd_ready = 1'b1;
    run_until_done(1, 100, ok);
    model_line(8, 0);
    ppl = 8'd3;
    pulse_written(); pulse_written();
    c = 0;
    @(negedge clk);
    while (!line_read_done && c < 100) begin @(negedge clk); c++; end
    line_written = 1'b1;
    @(posedge clk); #1 line_written = 1'b0;
    @(negedge clk);
    n_chk++;
    if (lines_avail !== CW'(2)) begin
      n_fail++; $display("FAIL coincide_avail: got %0d, expected 2", lines_avail);
    end
    @(posedge clk); #1;
    run_until_done(4, 200, ok);
    settle();
    model_line(3, 0); model_line(3, 0); model_line(3, 0);
    n_chk++;
    if (!ok || lines_avail !== '0) begin
      n_fail++; $display("FAIL throttle_done: done=%0d avail=%0d, expected 4 0", done_cnt, lines_avail);
    end
    n_chk++;
    if (gate_bad != 0 || pv_bad != 0) begin
      n_fail++; $display("FAIL throttle_gating: ungated_reads=%0d pv_errors=%0d, expected 0 0", gate_bad, pv_bad);
    end
    n_chk++;
    if (addr_q.size() != ea_q.size()) begin
      n_fail++; $display("FAIL throttle_len: got %0d reads, expected %0d", addr_q.size(), ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < addr_q.size(); i++) begin
      n_chk++;
      if (addr_q[i] !== ea_q[i] || vec_q[i] !== ev_q[i]) begin
        n_fail++;
        $display("FAIL throttle_rd[%0d]: addr=%0d re=%b, expected addr=%0d re=%b", i, addr_q[i], vec_q[i], ea_q[i], ev_q[i]);
      end
    end
  endtask

`ifdef DC_BU_LINE_REPEAT_EN
  task automatic test_repeat();
    bit ok;
    do_reset();
    en = 1'b1; rd_ready = 1'b1; ppl = 8'd3; line_repeat = 4'd2;
    pulse_written();
    run_until_done(1, 100, ok);
    settle();
    model_line(3, 2);
    n_chk++;
    if (!ok || done_cnt != 1 || addr_q.size() != ea_q.size()) begin
      n_fail++; $display("FAIL repeat_len: done=%0d reads=%0d, expected 1 %0d", done_cnt, addr_q.size(), ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < addr_q.size(); i++) begin
      n_chk++;
      if (addr_q[i] !== ea_q[i] || vec_q[i] !== ev_q[i]) begin
        n_fail++;
        $display("FAIL repeat_rd[%0d]: addr=%0d re=%b, expected addr=%0d re=%b", i, addr_q[i], vec_q[i], ea_q[i], ev_q[i]);
      end
    end
    n_chk++;
    if (cyc_q.size() == 9 && cyc_q[3] - cyc_q[2] != 2) begin
      n_fail++; $display("FAIL repeat_turnaround: gap=%0d cycles, expected 2", cyc_q[3] - cyc_q[2]);
    end
  endtask
`endif

  task automatic test_random_lines();
    localparam int N = 10;
    int plist[N];
    int rlist[N];
    int cum[N+1];
    int written, c, gaps;
    do_reset();
    cum[0] = 0;
    for (int k = 0; k < N; k++) begin
      plist[k] = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
`ifdef DC_BU_LINE_REPEAT_EN
      rlist[k] = $urandom_range(0, 2);
`else
      rlist[k] = 0;
`endif
      cum[k+1] = cum[k] + clamp_len(plist[k]) * (rlist[k] + 1);
      model_line(plist[k], rlist[k]);
    end
    written = 0;
    c = 0;
    while (done_cnt < N && c < 20000) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
      line_written = 1'b0;
      if (written < N && (written - done_cnt) < int'(BN) && $urandom_range(0, 2) == 0) begin
        line_written = 1'b1;
        written++;
      end
      if (addr_q.size() > cum[done_cnt]) begin
        ppl = PW'($urandom);
`ifdef DC_BU_LINE_REPEAT_EN
        line_repeat = 4'($urandom);
`endif
      end else begin
        ppl = PW'(plist[done_cnt]);
`ifdef DC_BU_LINE_REPEAT_EN
        line_repeat = 4'(rlist[done_cnt]);
`endif
      end
      @(posedge clk); #1;
      c++;
    end
    line_written = 1'b0; en = 1'b1;
    settle();
    n_chk++;
    if (done_cnt != N) begin n_fail++; $display("FAIL rand_timeout: done=%0d, expected %0d", done_cnt, N); end
    n_chk++;
    if (addr_q.size() != ea_q.size()) begin
      n_fail++; $display("FAIL rand_len: got %0d reads, expected %0d", addr_q.size(), ea_q.size());
    end
    for (int i = 0; i < ea_q.size() && i < addr_q.size(); i++) begin
      n_chk++;
      if (addr_q[i] !== ea_q[i] || vec_q[i] !== ev_q[i]) begin
        n_fail++;
        $display("FAIL rand_rd[%0d]: addr=%0d re=%b, expected addr=%0d re=%b", i, addr_q[i], vec_q[i], ea_q[i], ev_q[i]);
      end
    end
    gaps = 0;
    for (int i = 1; i < cyc_q.size(); i++)
      if (vec_q[i] != vec_q[i-1] && cyc_q[i] - cyc_q[i-1] < 3) gaps++;
    n_chk++;
    if (gaps != 0) begin n_fail++; $display("FAIL rand_line_gap: %0d short gaps, expected 0", gaps); end
    n_chk++;
    if (pv_cnt != ea_q.size() || pv_bad != 0 || gate_bad != 0) begin
      n_fail++;
      $display("FAIL rand_valid: pv=%0d pv_err=%0d ungated=%0d, expected %0d 0 0", pv_cnt, pv_bad, gate_bad, ea_q.size());
    end
    n_chk++;
    if (lines_avail !== '0 || overflow_err !== 1'b0 || buf_full !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_final: avail=%0d ovf=%b full=%b, expected 0 0 0", lines_avail, overflow_err, buf_full);
    end
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; rd_ready = 1'b0; line_written = 1'b0; ppl = '0;
`ifdef DC_BU_LINE_REPEAT_EN
    line_repeat = '0;
`endif
    @(posedge clk);
    test_reset();
    test_single_line();
    test_overflow();
    test_rotation();
    test_clamp_and_zero();
    test_throttle_and_coincide();
`ifdef DC_BU_LINE_REPEAT_EN
    test_repeat();
`endif
    test_random_lines();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
